// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg: shared types and helpers for the interval timer.
// Slice width, controller state encoding and slice decode helper.
package interval_timer_pkg;

  localparam int SLICE_W = 4;
  localparam int MAX_W   = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    TERM
  } itc_state_t;

  function automatic logic slice_all_ones(
    input logic [MAX_W-1:0] q,
    input int               k
  );
    return &q[k*SLICE_W +: SLICE_W];
  endfunction

endpackage

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: load/run/tick sequencer for a chain of 4-bit slices.
// Optional pause input in RUN when INTERVAL_TIMER_PAUSE_EN is defined.
module interval_timer_ctrl
  import interval_timer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     mr_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     periodic,
  input  logic [CNT_W-1:0]         period,
`ifdef INTERVAL_TIMER_PAUSE_EN
  input  logic                     pause,
`endif
  output logic                     busy,
  output logic                     tick,
  output logic                     cnt_mr,
  output logic                     cnt_load,
  output logic [CNT_W/SLICE_W-1:0] cnt_en,
  output logic [CNT_W-1:0]         cnt_d,
  input  logic [CNT_W-1:0]         cnt_q
);

  localparam int NS = CNT_W / SLICE_W;

  itc_state_t       state;
  itc_state_t       state_nx;
  logic [CNT_W-1:0] per_r;
  logic             term;
  logic             run_en;
  logic [NS-1:0]    low_ones;

  // Terminal count is read from q; slice carry is stale after a load.
  assign term = &cnt_q;

`ifdef INTERVAL_TIMER_PAUSE_EN
  assign run_en = (state == RUN) & ~pause;
`else
  assign run_en = (state == RUN);
`endif

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      state <= IDLE;
      per_r <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == LOAD)
        per_r <= period;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start && !stop) state_nx = LOAD;
      LOAD: state_nx = RUN;
      RUN:  if (term) state_nx = TERM;
      TERM: state_nx = periodic ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
    if (stop && state != IDLE)
      state_nx = IDLE;
  end

  assign low_ones[0] = 1'b1;

  // Slice k counts only when every lower slice is about to carry.
  for (genvar k = 1; k < NS; k++) begin : g_ripple
    assign low_ones[k] = low_ones[k-1]
                       & slice_all_ones(MAX_W'(cnt_q), k - 1);
  end

  for (genvar k = 0; k < NS; k++) begin : g_en
    assign cnt_en[k] = run_en & ~term & low_ones[k];
  end

  assign cnt_d = ~per_r;

  always_comb begin
    busy     = 1'b1;
    tick     = 1'b0;
    cnt_mr   = 1'b0;
    cnt_load = 1'b0;
    unique case (state)
      IDLE: begin
        busy   = 1'b0;
        cnt_mr = 1'b1;
      end
      LOAD: cnt_load = 1'b1;
      RUN:  ;
      TERM: tick = 1'b1;
      default: begin
        busy   = 1'b0;
        cnt_mr = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl: vector table, hand sequences and random run
// against a countdown-to-tick reference model and a counter chain model.
module tb_interval_timer_ctrl;

  localparam int CNT_W = 8;
  localparam int NS    = CNT_W / 4;
  localparam int ONES  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             mr_n;
  logic             start;
  logic             stop;
  logic             periodic;
  logic [CNT_W-1:0] period;
  logic             pause;
  logic             busy;
  logic             tick;
  logic             cnt_mr;
  logic             cnt_load;
  logic [NS-1:0]    cnt_en;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q = 8'hA5;

  int n_chk  = 0;
  int n_fail = 0;
  bit m_chk  = 1'b0;

  interval_timer_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .mr_n     (mr_n),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .period   (period),
`ifdef INTERVAL_TIMER_PAUSE_EN
    .pause    (pause),
`endif
    .busy     (busy),
    .tick     (tick),
    .cnt_mr   (cnt_mr),
    .cnt_load (cnt_load),
    .cnt_en   (cnt_en),
    .cnt_d    (cnt_d),
    .cnt_q    (cnt_q)
  );

  always #5 clk = ~clk;

  // Counter slice chain: sync clear, parallel load, per-slice enable.
  always @(posedge clk) begin
    if (cnt_mr)
      cnt_q <= '0;
    else if (cnt_load)
      cnt_q <= cnt_d;
    else
      for (int s = 0; s < NS; s++)
        if (cnt_en[s])
          cnt_q[s*4 +: 4] <= cnt_q[s*4 +: 4] + 4'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: m_k = edges remaining until the tick cycle.
  // LOAD has m_k = P+2, RUN has P+1..1, the tick cycle has 0.
  bit m_busy;
  int m_k;
  int m_per;

  always @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_per  <= 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        m_busy <= 1'b1;
        m_k    <= int'(period) + 2;
        m_per  <= int'(period);
      end
    end else if (stop) begin
      m_busy <= 1'b0;
    end else if (m_k == 0) begin
      if (periodic) begin
        m_k   <= int'(period) + 2;
        m_per <= int'(period);
      end else begin
        m_busy <= 1'b0;
      end
    end else if (!(pause && m_k >= 2 && m_k <= m_per + 1)) begin
      m_k <= m_k - 1;
    end
  end

  always @(negedge clk) begin
    bit            run;
    bit            ld;
    int            qx;
    int            mask;
    logic [NS-1:0] enx;
    if (m_chk && mr_n) begin
      run = m_busy && m_k >= 1 && m_k <= m_per + 1;
      ld  = m_busy && m_k == m_per + 2;
      qx  = ONES - (m_k - 1);
      enx = '0;
      if (run && m_k >= 2 && !pause)
        for (int s = 0; s < NS; s++) begin
          mask   = (1 << (4 * s)) - 1;
          enx[s] = (qx & mask) == mask;
        end
      chk("m_busy", 32'(busy), 32'(m_busy));
      chk("m_tick", 32'(tick), 32'(m_busy && m_k == 0));
      chk("m_mr", 32'(cnt_mr), 32'(!m_busy));
      chk("m_load", 32'(cnt_load), 32'(ld));
      chk("m_en", 32'(cnt_en), 32'(enx));
      if (ld)
        chk("m_d", 32'(cnt_d), 32'(~m_per & ONES));
      if (run)
        chk("m_q", 32'(cnt_q), 32'(qx));
    end
  end

  typedef struct {
    logic [7:0] p;
    bit         ss;
    int         stop_run;
    int         exp_tick;
    int         exp_busy;
  } vec_t;

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_mr"}, 32'(cnt_mr), 32'd1);
    chk({tag, "_load"}, 32'(cnt_load), 32'd0);
    chk({tag, "_en"}, 32'(cnt_en), 32'd0);
    chk({tag, "_d"}, 32'(cnt_d), 32'(ONES));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int e;
    int tk;
    int bc;
    bit en1ok;
    period   = v.p;
    periodic = 1'b0;
    start    = 1'b1;
    stop     = v.ss;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    e = 0; tk = 0; bc = 0; en1ok = 1'b1;
    while (busy && e < 600) begin
      bc++;
      @(posedge clk); #1;
      e++;
      if (tick && tk == 0) tk = e;
      stop = (v.stop_run > 0 && e == v.stop_run);
      if (busy && cnt_en[1] && cnt_q[3:0] != 4'hF) en1ok = 1'b0;
    end
    stop = 1'b0;
    chk($sformatf("v%0d_tick_edge", idx), 32'(tk), 32'(v.exp_tick));
    chk($sformatf("v%0d_busy_cyc", idx), 32'(bc), 32'(v.exp_busy));
    chk($sformatf("v%0d_en1", idx), 32'(en1ok), 32'd1);
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle_q", idx), 32'(cnt_q), 32'd0);
  endtask

  initial begin
    vec_t vt[7];
    int   t[4];
    int   nt;
    int   e;
    int   tk;

    vt[0] = '{8'd5,   1'b0, 0, 7,   8};
    vt[1] = '{8'd0,   1'b0, 0, 2,   3};
    vt[2] = '{8'hFF,  1'b0, 0, 257, 258};
    vt[3] = '{8'd1,   1'b0, 0, 3,   4};
    vt[4] = '{8'd3,   1'b1, 0, 0,   0};
    vt[5] = '{8'd9,   1'b0, 3, 0,   4};
    vt[6] = '{8'd130, 1'b0, 0, 132, 133};

    mr_n = 1'b0; start = 1'b0; stop = 1'b0;
    periodic = 1'b0; period = '0; pause = 1'b0;
    #1;
    chk_reset_vals("rst");
    repeat (2) @(posedge clk);
    #3 mr_n = 1'b1;
    m_chk = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_vec(vt[i], i);

    // Periodic P=2, then period drops to 0 during the third interval.
    period = 8'd2; periodic = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0; nt = 0;
    for (int i = 0; i < 4; i++) t[i] = 0;
    while (nt < 4 && e < 60) begin
      @(posedge clk); #1;
      e++;
      if (tick) begin
        t[nt] = e;
        nt++;
      end
      if (nt == 2 && e == t[1] + 1) period = 8'd0;
    end
    chk("per_first", 32'(t[0]), 32'd4);
    chk("per_gap1", 32'(t[1] - t[0]), 32'd5);
    chk("per_gap2", 32'(t[2] - t[1]), 32'd5);
    chk("per_gap3", 32'(t[3] - t[2]), 32'd3);
    periodic = 1'b0;
    e = 0;
    while (busy && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    chk("per_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a run.
    period = 8'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 mr_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(posedge clk);
    #3 mr_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_q_clr", 32'(cnt_q), 32'd0);
    run_vec(vt[0], 10);

`ifdef INTERVAL_TIMER_PAUSE_EN
    period = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0; tk = 0;
    while (busy && e < 40) begin
      @(posedge clk); #1;
      e++;
      if (tick && tk == 0) tk = e;
      if (e == 2) pause = 1'b1;
      if (e == 5) pause = 1'b0;
    end
    pause = 1'b0;
    chk("pause_tick", 32'(tk), 32'd9);
`endif

    // Random traffic; the reference model checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 40) == 0);
      periodic = 1'($urandom_range(0, 1));
      period   = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                             : 8'($urandom_range(0, 12));
`ifdef INTERVAL_TIMER_PAUSE_EN
      pause    = ($urandom_range(0, 3) == 0);
`endif
    end
    start = 1'b0; stop = 1'b1; pause = 1'b0;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("rand_end_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
